seg_display_ctrl: RTL
=====================

SEG_DISPLAY_CTRL -- requirements
Module: seg_display_ctrl

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of seven-segment digits driven (1..8).
REQ-002 SHALL have parameter BLINK_DIV, default 25000000, clock cycles per blink half-period (>=2).
REQ-003 SHALL have parameter SCROLL_DIV, default 12500000, clock cycles per scroll step (>=2).
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port load_valid  input  1  new display content offered.
REQ-007 SHALL have port load_ready  output  1  block can accept content.
REQ-008 SHALL have port load_data  input  5*NUM_DIGITS  one 5-bit symbol code per digit; digit 0 in bits [4:0] is the rightmost digit.
REQ-009 SHALL have port mode  input  2  00 static, 01 blink, 10 scroll-left, 11 treated as static.
REQ-010 SHALL have port segments  output  7*NUM_DIGITS  active-low segments per digit, bit order g..a, digit 0 in bits [6:0].

Function
REQ-011 SHALL map codes 0-9 to decimal digits: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-012 SHALL map letter codes: 10 E=0000110, 11 A=0001000, 12 S=0010010, 13 Y=0010001, 14 H=0001001, 15 r=0101111, 16 d=0100001, 17 L=1000111; all other codes (18-31) blank=1111111.
REQ-013 SHALL accept load_data into an internal symbol buffer on a rising clk edge where load_valid and load_ready are both 1.
REQ-014 SHALL use FSM states IDLE (buffer blank, load_ready=1), BUSY (load_ready=0), SHOW (load_ready=1); IDLE->BUSY and SHOW->BUSY on accept, BUSY->SHOW unconditionally after one cycle.
REQ-015 SHALL register segments; a newly accepted buffer appears on segments exactly 2 cycles after the accepting edge.
REQ-016 SHALL in mode 00 drive the decoded buffer continuously.
REQ-017 SHALL in mode 10 rotate the displayed symbols one digit left (digit i takes digit i-1, digit 0 takes digit NUM_DIGITS-1) every SCROLL_DIV cycles while in SHOW, wrapping indefinitely.
REQ-018 SHALL clear the scroll offset, scroll counter and blink counter on every accept and on every change of mode.
REQ-019 SHALL ignore load_valid while in BUSY; load_data is not sampled there.
REQ-020 SHALL with NUM_DIGITS=1 in mode 10 hold the single digit unchanged (rotation is identity).
REQ-021 SHALL keep segments all 1s while in IDLE regardless of mode.

Reset
REQ-022 SHALL on rst=1 immediately force: state IDLE, buffer all code 31, segments all 1s, load_ready 0, all counters 0, blink phase on.
REQ-023 SHALL drive load_ready=1 from the first rising clk edge after rst deasserts.
REQ-024 SHALL abandon any in-progress BUSY, scroll or blink on rst assertion mid-operation, with no partial buffer update retained.

Configuration
REQ-025 SHALL compile the blink feature only when macro SEG_BLINK_EN is defined: mode 01 alternates decoded buffer (phase on) and all-1s (phase off), phase toggling every BLINK_DIV cycles in SHOW, starting on.
REQ-026 SHALL when SEG_BLINK_EN is undefined treat mode 01 exactly as mode 00, with no blink counter present.

Verification (NUM_DIGITS=4, BLINK_DIV=4, SCROLL_DIV=3)
REQ-027 SHALL cover: rst pulse mid-BUSY -> segments=all 1s at once, load_ready=0 during reset, load_ready=1 one edge after release.
REQ-028 SHALL cover: mode 00, load codes {10,11,12,13} (EASY, digit 3 = E) -> after 2 cycles segments = E,A,S,Y; load_ready=0 for exactly one cycle.
REQ-029 SHALL cover: mode 10, load {14,11,15,16} (HArd) -> display rotates left every 3 cycles: HArd, Ardh, rdHA, dHAr, HArd.
REQ-030 SHALL cover: SEG_BLINK_EN defined, mode 01, load digits {1,2,3,4} -> 4 cycles "1234", 4 cycles all 1s, repeating; undefined -> steady "1234".
REQ-031 SHALL cover: load_valid held high through BUSY with changing data -> only first-edge data displayed; code 25 in any digit -> that digit 1111111.
REQ-032 SHALL cover: mode changed 10->00 mid-scroll -> offset cleared, unrotated buffer shown on next update.

Source files
------------

// File: rtl/seg_display_ctrl.sv
// Seven-segment display controller: buffered symbols, static/blink/scroll.
// Optional blink support is compiled in with `define SEG_BLINK_EN.
module seg_display_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int BLINK_DIV  = 25000000,
    parameter int SCROLL_DIV = 12500000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [5*NUM_DIGITS-1:0] load_data,
    input  logic [1:0]              mode,
    output logic [7*NUM_DIGITS-1:0] segments
);

    localparam int OW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int SW = $clog2(SCROLL_DIV);
    localparam logic [OW-1:0] OLAST = OW'(NUM_DIGITS - 1);
    localparam logic [SW-1:0] SLAST = SW'(SCROLL_DIV - 1);

    localparam logic [1:0] M_BLINK  = 2'b01;
    localparam logic [1:0] M_SCROLL = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        SHOW
    } state_t;

    state_t                    r_state;
    state_t                    w_next;
    logic                      r_ready;
    logic [5*NUM_DIGITS-1:0]   r_buf;
    logic [1:0]                r_mode;
    logic [SW-1:0]             r_scnt;
    logic [OW-1:0]             r_off;
    logic [7*NUM_DIGITS-1:0]   r_seg;
    logic [7*NUM_DIGITS-1:0]   w_seg_next;
    logic                      w_accept;
    logic                      w_clear;
    logic                      w_show;
    logic                      w_phase_on;

    assign load_ready = r_ready;
    assign segments   = r_seg;
    assign w_accept   = load_valid & r_ready;
    assign w_clear    = w_accept | (mode != r_mode);
    assign w_show     = (r_state == SHOW);

    // Active-low g..a pattern for one 5-bit symbol code.
    function automatic logic [6:0] f_decode(input logic [4:0] code);
        logic [6:0] seg;
        case (code)
            5'd0:    seg = 7'b1000000;
            5'd1:    seg = 7'b1111001;
            5'd2:    seg = 7'b0100100;
            5'd3:    seg = 7'b0110000;
            5'd4:    seg = 7'b0011001;
            5'd5:    seg = 7'b0010010;
            5'd6:    seg = 7'b0000010;
            5'd7:    seg = 7'b1111000;
            5'd8:    seg = 7'b0000000;
            5'd9:    seg = 7'b0010000;
            5'd10:   seg = 7'b0000110;
            5'd11:   seg = 7'b0001000;
            5'd12:   seg = 7'b0010010;
            5'd13:   seg = 7'b0010001;
            5'd14:   seg = 7'b0001001;
            5'd15:   seg = 7'b0101111;
            5'd16:   seg = 7'b0100001;
            5'd17:   seg = 7'b1000111;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

    // Next-state logic: one BUSY cycle after every accepted load.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_accept) w_next = BUSY;
            BUSY:    w_next = SHOW;
            SHOW:    if (w_accept) w_next = BUSY;
            default: w_next = IDLE;
        endcase
    end

    // State register; ready is registered so it stays low during reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_next;
            r_ready <= (w_next != BUSY);
        end
    end

    // Symbol buffer and previous mode for change detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buf  <= {NUM_DIGITS{5'd31}};
            r_mode <= 2'b00;
        end else begin
            r_mode <= mode;
            if (w_accept) r_buf <= load_data;
        end
    end

    // Scroll step counter and rotation offset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scnt <= '0;
            r_off  <= '0;
        end else if (w_clear) begin
            r_scnt <= '0;
            r_off  <= '0;
        end else if (w_show && mode == M_SCROLL) begin
            if (r_scnt == SLAST) begin
                r_scnt <= '0;
                r_off  <= (r_off == OLAST) ? '0 : r_off + OW'(1);
            end else begin
                r_scnt <= r_scnt + SW'(1);
            end
        end
    end

`ifdef SEG_BLINK_EN
    localparam int BW = $clog2(BLINK_DIV);
    localparam logic [BW-1:0] BLAST = BW'(BLINK_DIV - 1);

    logic [BW-1:0] r_bcnt;
    logic          r_phase;

    assign w_phase_on = r_phase;

    // Blink half-period counter and on/off phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bcnt  <= '0;
            r_phase <= 1'b1;
        end else if (w_clear) begin
            r_bcnt  <= '0;
            r_phase <= 1'b1;
        end else if (w_show && mode == M_BLINK) begin
            if (r_bcnt == BLAST) begin
                r_bcnt  <= '0;
                r_phase <= ~r_phase;
            end else begin
                r_bcnt <= r_bcnt + BW'(1);
            end
        end
    end
`else
    assign w_phase_on = 1'b1;
`endif

    // Decode buffer with rotation (scroll) and masking (blink off phase).
    always_comb begin
        int src;
        w_seg_next = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            src = i;
            if (mode == M_SCROLL) begin
                src = i - int'(r_off);
                if (src < 0) src = src + NUM_DIGITS;
            end
            w_seg_next[7*i +: 7] = f_decode(r_buf[5*src +: 5]);
        end
        if (mode == M_BLINK && !w_phase_on) w_seg_next = '1;
    end

    // Output register: blank in IDLE, hold through BUSY, update in SHOW.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg <= '1;
        end else if (r_state == SHOW) begin
            r_seg <= w_seg_next;
        end else if (r_state == IDLE) begin
            r_seg <= '1;
        end
    end

endmodule
